uart_tx_arbiter: RTL

Round-robin scheduler that shares one `uart_tx` transmitter among several byte producers. Each requester offers a byte via a valid/ready handshake; the arbiter grants one, holds its byte on `tx_data_in`, pulses `tx_start`, and blocks further grants until the 11-bit frame (start, 8 data, parity, stop) and an optional inter-frame gap have elapsed. It sits directly in front of `uart_tx` and drives its `tx_start` and `tx_data_in` inputs.

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for uart_tx_arbiter.
// master = requester side, slave = arbiter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic [IW-1:0]        grant_id;
  logic                 busy;

  modport master (
    output req_valid, req_data,
    input  req_ready, tx_start, tx_data, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, tx_start, tx_data, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among NUM_REQ producers.
// Define UART_ARB_PRIO0_EN to give requester 0 strict priority.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter int FRAME_BITS   = 11,
  parameter int GAP_CYCLES   = 0
) (
  input logic clk,
  input logic reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int F    = FRAME_BITS * CLKS_PER_BIT;
  localparam int CMAX = (F > GAP_CYCLES) ? F : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int GLD  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
`ifdef UART_ARB_PRIO0_EN
  localparam bit SKIP0 = 1'b1;
`else
  localparam bit SKIP0 = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_SEND, S_GAP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_data;
  logic [IW-1:0] r_gid;
  logic          w_found;
  logic [IW-1:0] w_win;
  logic          w_grant;
  logic          w_zero;

  assign w_zero  = (r_cnt == '0);
  assign w_grant = (r_state == S_IDLE) && w_found && !reset;

  // Search upward from the last grant so it ends up lowest priority
  always_comb begin : p_rr
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = r_gid;
    if (SKIP0 && bus.req_valid[0]) begin
      w_found = 1'b1;
      w_win   = '0;
    end
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(r_gid) + k) % NUM_REQ;
      if (!w_found && bus.req_valid[idx]
          && !(SKIP0 && idx == 0)) begin
        w_found = 1'b1;
        w_win   = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_grant) w_next = S_START;
      S_START: w_next = S_SEND;
      S_SEND:  if (w_zero)
                 w_next = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (w_zero) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_data <= 8'h00;
      r_gid  <= IW'(NUM_REQ - 1);
    end else begin
      if (w_grant) begin
        r_data <= bus.req_data[8*int'(w_win) +: 8];
        r_gid  <= w_win;
      end
      unique case (r_state)
        S_START: r_cnt <= CW'(F - 1);
        S_SEND:  if (!w_zero)             r_cnt <= r_cnt - 1'b1;
                 else if (GAP_CYCLES > 0) r_cnt <= CW'(GLD);
        S_GAP:   if (!w_zero) r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (w_grant) bus.req_ready[w_win] = 1'b1;
    bus.tx_start = (r_state == S_START);
    bus.busy     = (r_state != S_IDLE);
    bus.tx_data  = r_data;
    bus.grant_id = r_gid;
  end
endmodule
